// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide units.
package mdu_pkg;

   localparam int unsigned MDU_WIDTH = 32;
   localparam int unsigned MUL_CNT_W = $clog2(MDU_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mul_state_t;

endpackage

// File: rtl/multu.sv
// Sequential shift-add multiplier for MULT/MULTU: one partial-product step per cycle,
// then a final sign fix-up. Same start/busy/ready handshake as the divider.
module multu
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = MDU_WIDTH
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   z,
   output logic                 busy,
   output logic                 ready
);

   localparam int unsigned CntW = $clog2(WIDTH);

   mul_state_t           r_state;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_acc_hi;
   logic [CntW-1:0]      r_count;
   logic                 r_neg;
   logic [2*WIDTH-1:0]   r_z;
   logic                 r_busy;
   logic                 r_ready;

   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_prod;
   logic [2*WIDTH-1:0]   w_prod_neg;

   // Magnitude of the most negative value is itself, which is correct as unsigned.
   assign w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   assign w_sum      = {1'b0, r_acc_hi} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
   // Low product bits shift into the multiplier register as it empties.
   assign w_prod     = {r_acc_hi, r_mplier};
   assign w_prod_neg = ~w_prod + (2*WIDTH)'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc_hi <= '0;
         r_count  <= '0;
         r_neg    <= 1'b0;
         r_z      <= '0;
         r_busy   <= 1'b0;
         r_ready  <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= w_a_mag;
                  r_mplier <= w_b_mag;
                  r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_acc_hi <= '0;
                  r_count  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_acc_hi <= w_sum[WIDTH:1];
               r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
               r_count  <= r_count + CntW'(1);
               if (r_count == CntW'(WIDTH - 1)) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_z     <= r_neg ? w_prod_neg : w_prod;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign z     = r_z;
   assign busy  = r_busy;
   assign ready = r_ready;

endmodule

// File: tb/tb_multu.sv
// Directed self-checking bench for the sequential multiplier.
module tb_multu;

   logic        clock;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic [63:0] z;
   logic        busy;
   logic        ready;

   int n_tests;
   int n_fail;

   multu #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .z         (z),
      .busy      (busy),
      .ready     (ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Issue one operation and wait (bounded) for ready; returns edges after E0 and busy count.
   task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int busy_cnt);
      is_signed = s;
      a         = av;
      b         = bv;
      start     = 1'b1;
      cyc();
      start     = 1'b0;
      a         = 32'hDEAD_BEEF;
      b         = 32'h0BAD_F00D;
      lat       = 0;
      busy_cnt  = 0;
      while (!ready && lat < 100) begin
         if (busy) busy_cnt++;
         cyc();
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      n_tests++;
      if (z !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_z: got %h expected %h", z, 64'h0);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 0", ready);
      end
   endtask

   task automatic test_unsigned();
      int lat;
      int bc;
      run_op(1'b0, 32'd7, 32'd6, lat, bc);
      n_tests++;
      if (lat !== 33) begin
         n_fail++;
         $display("FAIL unsigned_latency: got %0d expected 33", lat);
      end
      n_tests++;
      if (bc !== 33) begin
         n_fail++;
         $display("FAIL unsigned_busy_cycles: got %0d expected 33", bc);
      end
      n_tests++;
      if (z !== 64'h0000_0000_0000_002A) begin
         n_fail++;
         $display("FAIL unsigned_7x6: got %h expected %h", z, 64'h2A);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_with_ready: got %b expected 0", busy);
      end
      cyc();
      n_tests++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_pulse_width: got %b expected 0", ready);
      end
   endtask

   task automatic test_vectors();
      logic        sv [6];
      logic [31:0] av [6];
      logic [31:0] bv [6];
      logic [63:0] ev [6];
      int lat;
      int bc;
      sv[0] = 1'b0; av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF; ev[0] = 64'hFFFF_FFFE_0000_0001;
      sv[1] = 1'b1; av[1] = 32'hFFFF_FFFD; bv[1] = 32'd5;         ev[1] = 64'hFFFF_FFFF_FFFF_FFF1;
      sv[2] = 1'b1; av[2] = 32'h8000_0000; bv[2] = 32'h8000_0000; ev[2] = 64'h4000_0000_0000_0000;
      sv[3] = 1'b1; av[3] = 32'hFFFF_FFFF; bv[3] = 32'hFFFF_FFFF; ev[3] = 64'h0000_0000_0000_0001;
      sv[4] = 1'b1; av[4] = 32'd100;       bv[4] = 32'hFFFF_FFF9; ev[4] = 64'hFFFF_FFFF_FFFF_FD44;
      sv[5] = 1'b1; av[5] = 32'd0;         bv[5] = 32'hFFFF_FFFF; ev[5] = 64'h0;
      for (int i = 0; i < 6; i++) begin
         run_op(sv[i], av[i], bv[i], lat, bc);
         n_tests++;
         if (lat !== 33 || z !== ev[i]) begin
            n_fail++;
            $display("FAIL vector_%0d: got z=%h lat=%0d expected z=%h lat=33",
                     i, z, lat, ev[i]);
         end
         cyc();
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      is_signed = 1'b0;
      a         = 32'd1000;
      b         = 32'd3;
      start     = 1'b1;
      cyc();
      start     = 1'b0;
      lat       = 0;
      while (!ready && lat < 100) begin
         if (lat == 10) begin
            is_signed = 1'b1;
            a         = 32'd5;
            b         = 32'hFFFF_FFFF;
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
         cyc();
         lat++;
      end
      start = 1'b0;
      n_tests++;
      if (lat !== 33 || z !== 64'd3000) begin
         n_fail++;
         $display("FAIL start_ignored: got z=%h lat=%0d expected z=%h lat=33",
                  z, lat, 64'd3000);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      int lat;
      int gap;
      int unstable;
      is_signed = 1'b0;
      a         = 32'd9;
      b         = 32'd11;
      start     = 1'b1;
      cyc();
      a         = 32'd3;
      b         = 32'd4;
      lat       = 0;
      while (!ready && lat < 100) begin
         cyc();
         lat++;
      end
      n_tests++;
      if (lat !== 33 || z !== 64'd99) begin
         n_fail++;
         $display("FAIL b2b_first: got z=%h lat=%0d expected z=%h lat=33", z, lat, 64'd99);
      end
      gap      = 0;
      unstable = 0;
      do begin
         cyc();
         gap++;
         if (!ready && z !== 64'd99) unstable++;
      end while (!ready && gap < 100);
      start = 1'b0;
      n_tests++;
      if (gap !== 34) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d expected 34", gap);
      end
      n_tests++;
      if (unstable !== 0) begin
         n_fail++;
         $display("FAIL b2b_z_hold: got %0d unstable cycles expected 0", unstable);
      end
      n_tests++;
      if (z !== 64'd12) begin
         n_fail++;
         $display("FAIL b2b_second: got %h expected %h", z, 64'd12);
      end
      cyc();
   endtask

   task automatic test_reset_midrun();
      int stray;
      int lat;
      int bc;
      is_signed = 1'b0;
      a         = 32'd77;
      b         = 32'd88;
      start     = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 14; i++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || ready !== 1'b0 || z !== 64'h0) begin
         n_fail++;
         $display("FAIL midrun_reset: got busy=%b ready=%b z=%h expected 0 0 0",
                  busy, ready, z);
      end
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (ready !== 1'b0 || busy !== 1'b0) stray++;
      end
      n_tests++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL aborted_no_ready: got %0d active cycles expected 0", stray);
      end
      run_op(1'b0, 32'h1234_5678, 32'h10, lat, bc);
      n_tests++;
      if (lat !== 33 || z !== 64'h0000_0001_2345_6780) begin
         n_fail++;
         $display("FAIL after_reset_op: got z=%h lat=%0d expected z=%h lat=33",
                  z, lat, 64'h0000_0001_2345_6780);
      end
      cyc();
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      a         = '0;
      b         = '0;
      test_reset();
      test_unsigned();
      test_vectors();
      test_start_ignored();
      test_back_to_back();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
